// File: rtl/bsg_fsb_axil_pkg.sv
// Shared types for the FSB <-> AXI-Lite bridges: command/response packet
// layouts, AXI-L response codes and the master-side FSM state encoding.
package bsg_fsb_axil_pkg;

    localparam int axil_addr_width_lp = 32;
    localparam int axil_data_width_lp = 32;
    localparam int axil_strb_width_lp = axil_data_width_lp / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axil_resp_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WRESP = 3'd2,
        RD    = 3'd3,
        RDATA = 3'd4,
        RSP   = 3'd5
    } m_axil_state_e;

    // 80-bit command packet arriving from the FSB node
    typedef struct packed {
        logic                          we;
        logic [axil_strb_width_lp-1:0] wstrb;
        logic                          ack_req;
        logic [1:0]                    rsvd;
        logic [7:0]                    tag;
        logic [axil_addr_width_lp-1:0] addr;
        logic [axil_data_width_lp-1:0] wdata;
    } fsb_axil_cmd_s;

    // 80-bit response packet returned to the FSB node
    typedef struct packed {
        logic                          we;
        axil_resp_e                    resp;
        logic [4:0]                    zero;
        logic [7:0]                    tag;
        logic [axil_addr_width_lp-1:0] addr;
        logic [axil_data_width_lp-1:0] rdata;
    } fsb_axil_rsp_s;

    // Assemble a response packet; the pad field is always driven to zero.
    function automatic fsb_axil_rsp_s make_rsp(
        input logic                          we,
        input axil_resp_e                    resp,
        input logic [7:0]                    tag,
        input logic [axil_addr_width_lp-1:0] addr,
        input logic [axil_data_width_lp-1:0] rdata
    );
        fsb_axil_rsp_s r;
        r.we    = we;
        r.resp  = resp;
        r.zero  = 5'd0;
        r.tag   = tag;
        r.addr  = addr;
        r.rdata = rdata;
        return r;
    endfunction

endpackage

// File: rtl/m_axil_fsb_adapter.sv
// FSB-to-AXI-Lite master bridge. Accepts one 80-bit FSB command at a time,
// performs a single-beat AXI-L read or write and, for reads and acked
// writes, returns an 80-bit response packet. All outputs are registered.
module m_axil_fsb_adapter
    import bsg_fsb_axil_pkg::*;
#(
    parameter int fsb_width_p       = 80,
    parameter int axil_addr_width_p = 32,
    parameter int axil_data_width_p = 32
) (
    input  logic                           clk_i,
    input  logic                           resetn_i,

    // FSB command in
    input  logic                           fsb_v_i,
    input  logic [fsb_width_p-1:0]         fsb_data_i,
    output logic                           fsb_ready_o,

    // FSB response out
    output logic                           fsb_v_o,
    output logic [fsb_width_p-1:0]         fsb_data_o,
    input  logic                           fsb_ready_i,

    // AXI-L write address
    output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
    output logic                           m_axil_awvalid_o,
    input  logic                           m_axil_awready_i,

    // AXI-L write data
    output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
    output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
    output logic                           m_axil_wvalid_o,
    input  logic                           m_axil_wready_i,

    // AXI-L write response
    input  logic [1:0]                     m_axil_bresp_i,
    input  logic                           m_axil_bvalid_i,
    output logic                           m_axil_bready_o,

    // AXI-L read address
    output logic [axil_addr_width_p-1:0]   m_axil_araddr_o,
    output logic                           m_axil_arvalid_o,
    input  logic                           m_axil_arready_i,

    // AXI-L read data
    input  logic [axil_data_width_p-1:0]   m_axil_rdata_i,
    input  logic [1:0]                     m_axil_rresp_i,
    input  logic                           m_axil_rvalid_i,
    output logic                           m_axil_rready_o
);

    fsb_axil_cmd_s cmd_in;
    fsb_axil_rsp_s rsp_out;

    m_axil_state_e state_r;

    // Registered handshake outputs
    logic fsb_ready_r;
    logic fsb_v_r;
    logic awvalid_r;
    logic wvalid_r;
    logic bready_r;
    logic arvalid_r;
    logic rready_r;

    // Write-channel completion flags; AW and W finish independently
    logic aw_done_r;
    logic w_done_r;

    // Command/response holding registers
    logic                           we_r;
    logic                           ack_req_r;
    logic [axil_data_width_p/8-1:0] wstrb_r;
    logic [7:0]                     tag_r;
    logic [axil_addr_width_p-1:0]   addr_r;
    logic [axil_data_width_p-1:0]   wdata_r;
    logic [axil_data_width_p-1:0]   rdata_r;
    axil_resp_e                     resp_r;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;

    // Reserved command bits carry no meaning for this bridge
    logic unused_rsvd;

    assign cmd_in      = fsb_axil_cmd_s'(fsb_data_i);
    assign unused_rsvd = ^cmd_in.rsvd;

    assign accept = fsb_v_i & fsb_ready_r;
    assign aw_hs  = awvalid_r & m_axil_awready_i;
    assign w_hs   = wvalid_r & m_axil_wready_i;
    assign aw_fin = aw_done_r | aw_hs;
    assign w_fin  = w_done_r | w_hs;

    // Main transaction FSM: one command in flight, every output registered
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_r     <= IDLE;
            fsb_ready_r <= 1'b0;
            fsb_v_r     <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            we_r        <= 1'b0;
            ack_req_r   <= 1'b0;
            wstrb_r     <= '0;
            tag_r       <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            rdata_r     <= '0;
            resp_r      <= OKAY;
        end else begin
            case (state_r)
                IDLE: begin
                    // Ready rises one cycle after reset release
                    fsb_ready_r <= 1'b1;
                    if (accept) begin
                        fsb_ready_r <= 1'b0;
                        we_r        <= cmd_in.we;
                        ack_req_r   <= cmd_in.ack_req;
                        wstrb_r     <= cmd_in.wstrb;
                        tag_r       <= cmd_in.tag;
                        addr_r      <= cmd_in.addr;
                        wdata_r     <= cmd_in.wdata;
                        rdata_r     <= '0;
                        resp_r      <= OKAY;
                        if (cmd_in.we) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            aw_done_r <= 1'b0;
                            w_done_r  <= 1'b0;
                            state_r   <= WR;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= RD;
                        end
                    end
                end

                WR: begin
                    if (aw_hs) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        bready_r  <= 1'b1;
                        state_r   <= WRESP;
                    end
                end

                WRESP: begin
                    if (m_axil_bvalid_i) begin
                        bready_r <= 1'b0;
                        resp_r   <= axil_resp_e'(m_axil_bresp_i);
                        if (ack_req_r) begin
                            fsb_v_r <= 1'b1;
                            state_r <= RSP;
                        end else begin
                            fsb_ready_r <= 1'b1;
                            state_r     <= IDLE;
                        end
                    end
                end

                RD: begin
                    if (m_axil_arready_i) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RDATA;
                    end
                end

                RDATA: begin
                    if (m_axil_rvalid_i) begin
                        rready_r <= 1'b0;
                        rdata_r  <= m_axil_rdata_i;
                        resp_r   <= axil_resp_e'(m_axil_rresp_i);
                        fsb_v_r  <= 1'b1;
                        state_r  <= RSP;
                    end
                end

                RSP: begin
                    // No same-cycle accept: ready appears the cycle after
                    if (fsb_ready_i) begin
                        fsb_v_r     <= 1'b0;
                        fsb_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end

                default: begin
                    fsb_ready_r <= 1'b0;
                    fsb_v_r     <= 1'b0;
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    bready_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    rready_r    <= 1'b0;
                    aw_done_r   <= 1'b0;
                    w_done_r    <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_out = make_rsp(we_r, resp_r, tag_r, addr_r, rdata_r);

    assign fsb_ready_o      = fsb_ready_r;
    assign fsb_v_o          = fsb_v_r;
    assign fsb_data_o       = rsp_out;

    assign m_axil_awaddr_o  = addr_r;
    assign m_axil_awvalid_o = awvalid_r;
    assign m_axil_wdata_o   = wdata_r;
    assign m_axil_wstrb_o   = wstrb_r;
    assign m_axil_wvalid_o  = wvalid_r;
    assign m_axil_bready_o  = bready_r;
    assign m_axil_araddr_o  = addr_r;
    assign m_axil_arvalid_o = arvalid_r;
    assign m_axil_rready_o  = rready_r;

endmodule

// File: tb/tb_m_axil_fsb_adapter.sv
// Self-checking bench for m_axil_fsb_adapter: directed scenarios followed by
// a random read/write run against a stalling AXI-L memory slave.
module tb_m_axil_fsb_adapter;

    logic        clk = 1'b0;
    logic        resetn_i = 1'b0;
    logic        fsb_v_i = 1'b0;
    logic [79:0] fsb_data_i = '0;
    logic        fsb_ready_o;
    logic        fsb_v_o;
    logic [79:0] fsb_data_o;
    logic        fsb_ready_i = 1'b0;
    logic [31:0] m_axil_awaddr_o;
    logic        m_axil_awvalid_o;
    logic        m_axil_awready_i = 1'b0;
    logic [31:0] m_axil_wdata_o;
    logic [3:0]  m_axil_wstrb_o;
    logic        m_axil_wvalid_o;
    logic        m_axil_wready_i = 1'b0;
    logic [1:0]  m_axil_bresp_i = 2'd0;
    logic        m_axil_bvalid_i = 1'b0;
    logic        m_axil_bready_o;
    logic [31:0] m_axil_araddr_o;
    logic        m_axil_arvalid_o;
    logic        m_axil_arready_i = 1'b0;
    logic [31:0] m_axil_rdata_i = '0;
    logic [1:0]  m_axil_rresp_i = 2'd0;
    logic        m_axil_rvalid_i = 1'b0;
    logic        m_axil_rready_o;

    m_axil_fsb_adapter dut (
        .clk_i            (clk),
        .resetn_i         (resetn_i),
        .fsb_v_i          (fsb_v_i),
        .fsb_data_i       (fsb_data_i),
        .fsb_ready_o      (fsb_ready_o),
        .fsb_v_o          (fsb_v_o),
        .fsb_data_o       (fsb_data_o),
        .fsb_ready_i      (fsb_ready_i),
        .m_axil_awaddr_o  (m_axil_awaddr_o),
        .m_axil_awvalid_o (m_axil_awvalid_o),
        .m_axil_awready_i (m_axil_awready_i),
        .m_axil_wdata_o   (m_axil_wdata_o),
        .m_axil_wstrb_o   (m_axil_wstrb_o),
        .m_axil_wvalid_o  (m_axil_wvalid_o),
        .m_axil_wready_i  (m_axil_wready_i),
        .m_axil_bresp_i   (m_axil_bresp_i),
        .m_axil_bvalid_i  (m_axil_bvalid_i),
        .m_axil_bready_o  (m_axil_bready_o),
        .m_axil_araddr_o  (m_axil_araddr_o),
        .m_axil_arvalid_o (m_axil_arvalid_o),
        .m_axil_arready_i (m_axil_arready_i),
        .m_axil_rdata_i   (m_axil_rdata_i),
        .m_axil_rresp_i   (m_axil_rresp_i),
        .m_axil_rvalid_i  (m_axil_rvalid_i),
        .m_axil_rready_o  (m_axil_rready_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int proto_err = 0;
    int rsp_hs_cnt = 0;
    int exp_total = 0;
    logic [79:0] exp_q[$];

    // Slave configuration and state
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] cfg_bresp = 2'd0, cfg_rresp = 2'd0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit aw_got = 0, w_got = 0, ar_got = 0;
    logic [31:0] sl_awaddr = '0, sl_wdata = '0, sl_araddr = '0;
    logic [3:0]  sl_wstrb = '0;
    logic p_awvalid = 0, p_wvalid = 0, p_bready = 0, p_arvalid = 0, p_rready = 0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
    logic [3:0]  p_wstrb = '0;
    logic [31:0] slave_mem [16];
    logic [31:0] ref_mem [16];

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [79:0] mk_rsp(input logic we, input logic [1:0] resp,
                                           input logic [7:0] tag, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        return {we, resp, 5'b00000, tag, addr, rdata};
    endfunction

    // AXI-L memory slave with per-channel programmable stalls, driven on negedge
    always @(negedge clk) begin
        if (!resetn_i) begin
            m_axil_awready_i = 0; m_axil_wready_i = 0; m_axil_bvalid_i = 0;
            m_axil_arready_i = 0; m_axil_rvalid_i = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (m_axil_awready_i && p_awvalid) begin
                aw_got = 1; sl_awaddr = p_awaddr; m_axil_awready_i = 0; aw_cnt = 0;
            end
            if (m_axil_wready_i && p_wvalid) begin
                w_got = 1; sl_wdata = p_wdata; sl_wstrb = p_wstrb; m_axil_wready_i = 0; w_cnt = 0;
            end
            if (m_axil_bvalid_i && p_bready) m_axil_bvalid_i = 0;
            if (m_axil_arready_i && p_arvalid) begin
                ar_got = 1; sl_araddr = p_araddr; m_axil_arready_i = 0; ar_cnt = 0;
            end
            if (m_axil_rvalid_i && p_rready) m_axil_rvalid_i = 0;

            if (m_axil_awvalid_o && !m_axil_awready_i && !aw_got) begin
                if (aw_cnt >= aw_dly) m_axil_awready_i = 1; else aw_cnt++;
            end
            if (m_axil_wvalid_o && !m_axil_wready_i && !w_got) begin
                if (w_cnt >= w_dly) m_axil_wready_i = 1; else w_cnt++;
            end
            if (m_axil_arvalid_o && !m_axil_arready_i && !ar_got) begin
                if (ar_cnt >= ar_dly) m_axil_arready_i = 1; else ar_cnt++;
            end
            if (aw_got && w_got && !m_axil_bvalid_i) begin
                if (b_cnt >= b_dly) begin
                    slave_mem[sl_awaddr[5:2]] = merge(slave_mem[sl_awaddr[5:2]], sl_wdata, sl_wstrb);
                    m_axil_bvalid_i = 1; m_axil_bresp_i = cfg_bresp;
                    aw_got = 0; w_got = 0; b_cnt = 0;
                end else b_cnt++;
            end
            if (ar_got && !m_axil_rvalid_i) begin
                if (r_cnt >= r_dly) begin
                    m_axil_rvalid_i = 1; m_axil_rdata_i = slave_mem[sl_araddr[5:2]];
                    m_axil_rresp_i = cfg_rresp; ar_got = 0; r_cnt = 0;
                end else r_cnt++;
            end
        end
        p_awvalid = m_axil_awvalid_o; p_awaddr = m_axil_awaddr_o;
        p_wvalid  = m_axil_wvalid_o;  p_wdata  = m_axil_wdata_o; p_wstrb = m_axil_wstrb_o;
        p_bready  = m_axil_bready_o;
        p_arvalid = m_axil_arvalid_o; p_araddr = m_axil_araddr_o;
        p_rready  = m_axil_rready_o;
    end

    // Protocol monitor: a pending valid must hold with a stable payload
    logic mon_rst = 0, mon_awv = 0, mon_awr = 0, mon_wv = 0, mon_wr = 0;
    logic mon_arv = 0, mon_arr = 0, mon_fv = 0, mon_fr = 0;
    logic [31:0] mon_awa = '0, mon_wd = '0, mon_ara = '0;
    logic [3:0]  mon_ws = '0;
    logic [79:0] mon_fd = '0;
    always @(negedge clk) begin
        #2;
        if (resetn_i && mon_rst) begin
            if (mon_awv && !mon_awr && (!m_axil_awvalid_o || m_axil_awaddr_o !== mon_awa)) proto_err++;
            if (mon_wv && !mon_wr && (!m_axil_wvalid_o || m_axil_wdata_o !== mon_wd ||
                                      m_axil_wstrb_o !== mon_ws)) proto_err++;
            if (mon_arv && !mon_arr && (!m_axil_arvalid_o || m_axil_araddr_o !== mon_ara)) proto_err++;
            if (mon_fv && !mon_fr && (!fsb_v_o || fsb_data_o !== mon_fd)) proto_err++;
            if (m_axil_bready_o && (m_axil_awvalid_o || m_axil_wvalid_o || m_axil_arvalid_o)) proto_err++;
        end
        mon_rst = resetn_i;
        mon_awv = m_axil_awvalid_o; mon_awr = m_axil_awready_i; mon_awa = m_axil_awaddr_o;
        mon_wv  = m_axil_wvalid_o;  mon_wr  = m_axil_wready_i;  mon_wd  = m_axil_wdata_o;
        mon_ws  = m_axil_wstrb_o;
        mon_arv = m_axil_arvalid_o; mon_arr = m_axil_arready_i; mon_ara = m_axil_araddr_o;
        mon_fv  = fsb_v_o; mon_fr = fsb_ready_i; mon_fd = fsb_data_o;
    end

    // Count every response handshake seen on the FSB side
    always @(posedge clk) begin
        if (resetn_i && fsb_v_o && fsb_ready_i) rsp_hs_cnt <= rsp_hs_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one command and return one cycle after it was accepted
    task automatic send(input logic we, input logic [3:0] strb, input logic ack,
                        input logic [7:0] tag, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        while (!fsb_ready_o && n < 60) begin step(); n++; end
        chk("send_ready", 80'(fsb_ready_o), 80'd1);
        fsb_data_i = {we, strb, ack, 2'b11, tag, addr, wdata};
        fsb_v_i = 1'b1;
        step();
        fsb_v_i = 1'b0;
        fsb_data_i = '0;
    endtask

    task automatic push_exp(input logic [79:0] e);
        exp_q.push_back(e);
        exp_total++;
    endtask

    // Wait for a response, optionally stall it, then compare against the scoreboard
    task automatic consume(input int stall);
        int n = 0;
        logic [79:0] e;
        while (!fsb_v_o && n < 100) begin step(); n++; end
        chk("rsp_arrive", 80'(fsb_v_o), 80'd1);
        if (fsb_v_o) begin
            repeat (stall) step();
            fsb_ready_i = 1'b1;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 80'hx;
            chk("rsp_data", fsb_data_o, e);
            step();
            fsb_ready_i = 1'b0;
            chk("rsp_v_drop", 80'(fsb_v_o), 80'd0);
            chk("rsp_ready_back", 80'(fsb_ready_o), 80'd1);
        end
    endtask

    initial begin
        int n;
        int bp_bad;
        bit seen_v;
        logic [79:0] held;
        int hs_before;

        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 32'hA500_0000 | 32'(i);
            ref_mem[i]   = 32'hA500_0000 | 32'(i);
        end
        slave_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]   = 32'hDEAD_BEEF;

        // Reset state
        step();
        chk("rst_fsb_ready", 80'(fsb_ready_o), 80'd0);
        chk("rst_fsb_v", 80'(fsb_v_o), 80'd0);
        chk("rst_fsb_data", fsb_data_o, 80'd0);
        chk("rst_valids", 80'({m_axil_awvalid_o, m_axil_wvalid_o, m_axil_arvalid_o,
                               m_axil_bready_o, m_axil_rready_o}), 80'd0);
        resetn_i = 1'b1;
        chk("rel_ready_low", 80'(fsb_ready_o), 80'd0);
        step();
        chk("rel_ready_rise", 80'(fsb_ready_o), 80'd1);

        // Zero-wait read returning DEADBEEF
        push_exp(mk_rsp(1'b0, 2'd0, 8'h5A, 32'h10, 32'hDEAD_BEEF));
        send(1'b0, 4'h0, 1'b0, 8'h5A, 32'h0000_0010, 32'h0);
        chk("rd_arvalid_c1", 80'(m_axil_arvalid_o), 80'd1);
        chk("rd_araddr", 80'(m_axil_araddr_o), 80'h10);
        chk("rd_ready_busy", 80'(fsb_ready_o), 80'd0);
        step();
        chk("rd_v_c2", 80'(fsb_v_o), 80'd0);
        chk("rd_rready_c2", 80'(m_axil_rready_o), 80'd1);
        step();
        chk("rd_v_c3", 80'(fsb_v_o), 80'd1);
        consume(0);

        // Acked write, awready three cycles ahead of wready
        w_dly = 3;
        ref_mem[8] = merge(ref_mem[8], 32'h1234_5678, 4'hF);
        push_exp(mk_rsp(1'b1, 2'd0, 8'h11, 32'h20, 32'h0));
        send(1'b1, 4'hF, 1'b1, 8'h11, 32'h0000_0020, 32'h1234_5678);
        chk("wr_valids_c1", 80'({m_axil_awvalid_o, m_axil_wvalid_o}), 80'b11);
        chk("wr_awaddr", 80'(m_axil_awaddr_o), 80'h20);
        chk("wr_wdata_strb", 80'({m_axil_wdata_o, m_axil_wstrb_o}), 80'({32'h1234_5678, 4'hF}));
        step();
        chk("wr_valids_c2", 80'({m_axil_awvalid_o, m_axil_wvalid_o}), 80'b01);
        step();
        step();
        chk("wr_valids_c4", 80'({m_axil_awvalid_o, m_axil_wvalid_o}), 80'b01);
        step();
        chk("wr_valids_c5", 80'({m_axil_awvalid_o, m_axil_wvalid_o}), 80'b00);
        consume(0);
        w_dly = 0;

        // Unacked write with SLVERR: no response, ready right after B handshake
        cfg_bresp = 2'd2;
        b_dly = 2;
        hs_before = rsp_hs_cnt;
        ref_mem[9] = merge(ref_mem[9], 32'hCAFE_F00D, 4'h3);
        send(1'b1, 4'h3, 1'b0, 8'h22, 32'h0000_0024, 32'hCAFE_F00D);
        n = 0;
        seen_v = 0;
        while (!(m_axil_bvalid_i && m_axil_bready_o) && n < 50) begin
            if (fsb_v_o) seen_v = 1;
            step();
            n++;
        end
        chk("slverr_b_hs", 80'(m_axil_bvalid_i && m_axil_bready_o), 80'd1);
        step();
        chk("slverr_ready_next", 80'(fsb_ready_o), 80'd1);
        repeat (3) begin
            if (fsb_v_o) seen_v = 1;
            step();
        end
        chk("slverr_no_rsp", 80'(seen_v), 80'd0);
        chk("slverr_no_hs", 80'(rsp_hs_cnt), 80'(hs_before));
        cfg_bresp = 2'd0;
        b_dly = 0;

        // Backpressure on the response: 10 cycles of fsb_ready_i=0
        push_exp(mk_rsp(1'b0, 2'd0, 8'h33, 32'h20, ref_mem[8]));
        send(1'b0, 4'h0, 1'b0, 8'h33, 32'h0000_0020, 32'h0);
        n = 0;
        while (!fsb_v_o && n < 50) begin step(); n++; end
        held = fsb_data_o;
        bp_bad = 0;
        repeat (10) begin
            step();
            if (fsb_data_o !== held || fsb_ready_o || !fsb_v_o || m_axil_awvalid_o ||
                m_axil_wvalid_o || m_axil_arvalid_o) bp_bad++;
        end
        chk("bp_stable", 80'(bp_bad), 80'd0);
        consume(0);

        // Read returning DECERR, passed through unchanged
        cfg_rresp = 2'd3;
        push_exp(mk_rsp(1'b0, 2'd3, 8'h34, 32'h24, ref_mem[9]));
        send(1'b0, 4'h0, 1'b0, 8'h34, 32'h0000_0024, 32'h0);
        consume(2);
        cfg_rresp = 2'd0;

        // wstrb=0 write then read back: memory unchanged
        push_exp(mk_rsp(1'b1, 2'd0, 8'h35, 32'h28, 32'h0));
        send(1'b1, 4'h0, 1'b1, 8'h35, 32'h0000_0028, 32'hFFFF_FFFF);
        chk("strb0_wstrb", 80'(m_axil_wstrb_o), 80'd0);
        consume(0);
        push_exp(mk_rsp(1'b0, 2'd0, 8'h36, 32'h28, ref_mem[10]));
        send(1'b0, 4'h0, 1'b0, 8'h36, 32'h0000_0028, 32'h0);
        consume(0);

        // Asynchronous reset while arvalid is pending
        ar_dly = 20;
        hs_before = rsp_hs_cnt;
        send(1'b0, 4'h0, 1'b0, 8'h44, 32'h0000_0030, 32'h0);
        chk("mid_arvalid", 80'(m_axil_arvalid_o), 80'd1);
        step();
        #2;
        resetn_i = 1'b0;
        #1;
        chk("mid_rst_arvalid", 80'(m_axil_arvalid_o), 80'd0);
        chk("mid_rst_fsb_v", 80'(fsb_v_o), 80'd0);
        chk("mid_rst_ready", 80'(fsb_ready_o), 80'd0);
        step();
        step();
        resetn_i = 1'b1;
        ar_dly = 0;
        step();
        chk("mid_rel_ready", 80'(fsb_ready_o), 80'd1);
        seen_v = 0;
        repeat (5) begin
            if (fsb_v_o || m_axil_arvalid_o) seen_v = 1;
            step();
        end
        chk("mid_no_stale", 80'(seen_v), 80'd0);
        chk("mid_no_hs", 80'(rsp_hs_cnt), 80'(hs_before));

        // Back-to-back random traffic against a stalling memory slave
        for (int i = 0; i < 100; i++) begin
            logic        we;
            logic        ack;
            logic [3:0]  strb;
            logic [3:0]  idx;
            logic [31:0] wd;
            aw_dly = $urandom_range(3, 0);
            w_dly  = $urandom_range(3, 0);
            b_dly  = $urandom_range(3, 0);
            ar_dly = $urandom_range(3, 0);
            r_dly  = $urandom_range(3, 0);
            we   = 1'($urandom_range(1, 0));
            ack  = 1'($urandom_range(1, 0));
            strb = 4'($urandom_range(15, 0));
            idx  = 4'($urandom_range(15, 0));
            wd   = $urandom;
            if (we) begin
                ref_mem[idx] = merge(ref_mem[idx], wd, strb);
                if (ack) push_exp(mk_rsp(1'b1, 2'd0, 8'(i), {26'd0, idx, 2'b00}, 32'h0));
                send(1'b1, strb, ack, 8'(i), {26'd0, idx, 2'b00}, wd);
                if (ack) consume($urandom_range(3, 0));
                else begin
                    n = 0;
                    while (!fsb_ready_o && n < 60) begin step(); n++; end
                    chk("rnd_wr_done", 80'(fsb_ready_o), 80'd1);
                end
            end else begin
                push_exp(mk_rsp(1'b0, 2'd0, 8'(i), {26'd0, idx, 2'b00}, ref_mem[idx]));
                send(1'b0, 4'h0, 1'b0, 8'(i), {26'd0, idx, 2'b00}, 32'h0);
                consume($urandom_range(3, 0));
            end
        end

        repeat (3) step();
        chk("rsp_total", 80'(rsp_hs_cnt), 80'(exp_total));
        chk("scoreboard_empty", 80'(exp_q.size()), 80'd0);
        chk("protocol", 80'(proto_err), 80'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
